// File: rtl/lock_pkg.sv
// Shared constants for the keypad lock sequencer: state encoding and default secret.
package lock_pkg;

  localparam logic [2:0] ST_LOCKED   = 3'd0;
  localparam logic [2:0] ST_ENTRY    = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_UNLOCKED = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;
  localparam logic [2:0] ST_LOCKOUT  = 3'd5;
  localparam logic [2:0] ST_PROGRAM  = 3'd6;

  localparam int          DFLT_DIGIT_W  = 4;
  localparam int          DFLT_CODE_LEN = 4;
  localparam logic [15:0] DFLT_CODE     = 16'h1234;

endpackage

// File: rtl/press_detect.sv
// Rising-edge detector on the enter level: one pulse per press, none while held.
module press_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_enter,
  output logic o_press
);

  logic r_enter_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_enter_q <= 1'b0;
    else       r_enter_q <= i_enter;
  end

  assign o_press = i_enter & ~r_enter_q;

endmodule

// File: rtl/lock_sequencer.sv
// Keypad lock controller: code entry and compare, failure/lockout tracking,
// timed auto-relock and secret reprogramming while unlocked.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int CODE_LEN       = DFLT_CODE_LEN,
  parameter int DIGIT_W        = DFLT_DIGIT_W,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = (CODE_LEN*DIGIT_W)'(DFLT_CODE),
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 1000,
  parameter int ERR_CYCLES     = 100,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int ENTRY_TIMEOUT  = 2000,
  parameter int TMR_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enter,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               prog,
  output logic               locked,
  output logic               unlocked,
  output logic               error,
  output logic               lockout_o,
  output logic [2:0]         state_o,
  output logic [1:0]         digit_idx,
  output logic [1:0]         fail_cnt
);

  localparam int CW = CODE_LEN * DIGIT_W;

  logic               w_press;
  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [CW-1:0]      r_code;
  logic [CW-1:0]      r_shadow;
  logic [CW-1:0]      w_shadow_nxt;
  logic [1:0]         r_idx;
  logic [1:0]         r_fail;
  logic [TMR_W-1:0]   r_timer;
  logic               r_mismatch;
  logic [DIGIT_W-1:0] w_exp_digit;
  logic               w_digit_bad;
  logic               w_last;
  logic               w_tmr_zero;
  logic               w_tmr_run;
  logic               w_fail_limit;

  press_detect u_press_detect (
    .clk     (clk),
    .reset   (reset),
    .i_enter (enter),
    .o_press (w_press)
  );

  // idx is zero outside ENTRY/PROGRAM, so the same slot select serves digit 0 in LOCKED.
  always_comb begin
    w_exp_digit  = r_code[DIGIT_W*(CODE_LEN-1-int'(r_idx)) +: DIGIT_W];
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[DIGIT_W*(CODE_LEN-1-int'(r_idx)) +: DIGIT_W] = digit;
  end

  assign w_digit_bad  = (digit != w_exp_digit);
  assign w_last       = (int'(r_idx) == CODE_LEN - 1);
  assign w_tmr_zero   = (r_timer == '0);
  assign w_fail_limit = (int'(r_fail) + 1 == MAX_FAILS);
  assign w_tmr_run    = r_state inside {ST_ENTRY, ST_ERROR, ST_LOCKOUT, ST_UNLOCKED, ST_PROGRAM};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_LOCKED;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOCKED: begin
        if (w_press) w_state_nxt = (CODE_LEN == 1) ? ST_CHECK : ST_ENTRY;
      end
      ST_ENTRY: begin
        if (w_press) begin
          if (w_last) w_state_nxt = ST_CHECK;
        end else if (w_tmr_zero) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_CHECK: begin
        if (!r_mismatch)       w_state_nxt = ST_UNLOCKED;
        else if (w_fail_limit) w_state_nxt = ST_LOCKOUT;
        else                   w_state_nxt = ST_ERROR;
      end
      ST_ERROR, ST_LOCKOUT: begin
        if (w_tmr_zero) w_state_nxt = ST_LOCKED;
      end
      ST_UNLOCKED: begin
        if (w_press)         w_state_nxt = prog ? ST_PROGRAM : ST_LOCKED;
        else if (w_tmr_zero) w_state_nxt = ST_LOCKED;
      end
      ST_PROGRAM: begin
        if (w_press) begin
          if (w_last) w_state_nxt = ST_LOCKED;
        end else if (w_tmr_zero) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_LOCKED;
    endcase
  end

  // Later assignments in the case override the default timer decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_code     <= DEFAULT_CODE;
      r_shadow   <= '0;
      r_idx      <= '0;
      r_fail     <= '0;
      r_timer    <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_tmr_run && !w_tmr_zero) r_timer <= r_timer - 1'b1;
      case (r_state)
        ST_LOCKED: begin
          if (w_press) begin
            r_mismatch <= w_digit_bad;
            r_idx      <= w_last ? 2'd0 : 2'd1;
            r_timer    <= TMR_W'(ENTRY_TIMEOUT - 1);
          end
        end
        ST_ENTRY: begin
          if (w_press) begin
            r_mismatch <= r_mismatch | w_digit_bad;
            r_idx      <= w_last ? 2'd0 : r_idx + 2'd1;
            r_timer    <= TMR_W'(ENTRY_TIMEOUT - 1);
          end else if (w_tmr_zero) begin
            r_idx <= '0;
          end
        end
        ST_CHECK: begin
          if (!r_mismatch) begin
            r_fail  <= '0;
            r_timer <= TMR_W'(UNLOCK_CYCLES - 1);
          end else if (w_fail_limit) begin
            r_fail  <= 2'(MAX_FAILS);
            r_timer <= TMR_W'(LOCKOUT_CYCLES - 1);
          end else begin
            r_fail  <= r_fail + 2'd1;
            r_timer <= TMR_W'(ERR_CYCLES - 1);
          end
        end
        ST_LOCKOUT: begin
          if (w_tmr_zero) r_fail <= '0;
        end
        ST_UNLOCKED: begin
          if (w_press && prog) begin
            r_idx   <= '0;
            r_timer <= TMR_W'(UNLOCK_CYCLES - 1);
          end
        end
        ST_PROGRAM: begin
          if (w_press) begin
            r_shadow <= w_shadow_nxt;
            r_timer  <= TMR_W'(UNLOCK_CYCLES - 1);
            if (w_last) begin
              r_code <= w_shadow_nxt;
              r_idx  <= '0;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else if (w_tmr_zero) begin
            r_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    locked    = r_state inside {ST_LOCKED, ST_ENTRY, ST_CHECK, ST_ERROR, ST_LOCKOUT};
    unlocked  = r_state inside {ST_UNLOCKED, ST_PROGRAM};
    error     = r_state inside {ST_ERROR, ST_LOCKOUT};
    lockout_o = (r_state == ST_LOCKOUT);
    state_o   = r_state;
    digit_idx = r_idx;
    fail_cnt  = r_fail;
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: vector table, directed corner sequences and random
// presses checked every cycle against a queue-based model of the lock.
module tb_lock_sequencer;

  localparam int UC = 20;
  localparam int EC = 5;
  localparam int LC = 10;
  localparam int ET = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic       prog = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       locked, unlocked, error, lockout_o;
  logic [2:0] state_o;
  logic [1:0] digit_idx, fail_cnt;

  always #5 clk = ~clk;

  lock_sequencer #(
    .UNLOCK_CYCLES  (UC),
    .ERR_CYCLES     (EC),
    .LOCKOUT_CYCLES (LC),
    .ENTRY_TIMEOUT  (ET)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enter     (enter),
    .digit     (digit),
    .prog      (prog),
    .locked    (locked),
    .unlocked  (unlocked),
    .error     (error),
    .lockout_o (lockout_o),
    .state_o   (state_o),
    .digit_idx (digit_idx),
    .fail_cnt  (fail_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: digits collected in queues, whole code compared at once, timers as remaining counts.
  int m_st = 0;
  int m_fail = 0;
  int m_timer = 0;
  int m_code[4] = '{1, 2, 3, 4};
  int m_q[$];
  int m_sh[$];
  bit m_prev = 1'b0;

  function automatic void model_step(bit en, int d, bit p);
    bit pr;
    bit ok;
    pr = en && !m_prev;
    m_prev = en;
    case (m_st)
      0: if (pr) begin m_q.delete(); m_q.push_back(d); m_timer = ET - 1; m_st = 1; end
      1: begin
        if (pr) begin
          m_q.push_back(d); m_timer = ET - 1;
          if (m_q.size() == 4) m_st = 2;
        end else if (m_timer == 0) begin m_st = 0; m_q.delete(); end
        else m_timer--;
      end
      2: begin
        ok = 1'b1;
        foreach (m_q[i]) if (m_q[i] != m_code[i]) ok = 1'b0;
        m_q.delete();
        if (ok) begin m_st = 3; m_fail = 0; m_timer = UC - 1; end
        else if (m_fail + 1 == 3) begin m_st = 5; m_fail = 3; m_timer = LC - 1; end
        else begin m_st = 4; m_fail++; m_timer = EC - 1; end
      end
      4: if (m_timer == 0) m_st = 0; else m_timer--;
      5: if (m_timer == 0) begin m_st = 0; m_fail = 0; end else m_timer--;
      3: begin
        if (pr) begin
          if (p) begin m_st = 6; m_sh.delete(); m_timer = UC - 1; end
          else m_st = 0;
        end else if (m_timer == 0) m_st = 0;
        else m_timer--;
      end
      6: begin
        if (pr) begin
          m_sh.push_back(d); m_timer = UC - 1;
          if (m_sh.size() == 4) begin
            foreach (m_code[i]) m_code[i] = m_sh[i];
            m_sh.delete(); m_st = 0;
          end
        end else if (m_timer == 0) begin m_st = 0; m_sh.delete(); end
        else m_timer--;
      end
      default: m_st = 0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st = 0; m_fail = 0; m_timer = 0; m_prev = 1'b0;
      m_code = '{1, 2, 3, 4};
      m_q.delete(); m_sh.delete();
    end else begin
      model_step(enter, int'(digit), prog);
    end
  end

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk("cyc_locked",   int'(locked),    int'(m_st inside {0, 1, 2, 4, 5}));
      chk("cyc_unlocked", int'(unlocked),  int'(m_st inside {3, 6}));
      chk("cyc_error",    int'(error),     int'(m_st inside {4, 5}));
      chk("cyc_lockout",  int'(lockout_o), int'(m_st == 5));
      chk("cyc_state",    int'(state_o),   m_st);
      chk("cyc_idx",      int'(digit_idx), (m_st == 1) ? m_q.size() : (m_st == 6) ? m_sh.size() : 0);
      chk("cyc_fail",     int'(fail_cnt),  m_fail);
    end
  end

  task automatic cyc(bit en, int d, bit p);
    @(negedge clk);
    #1;
    enter = en; digit = 4'(d); prog = p;
  endtask

  task automatic press(int d, bit p);
    cyc(1'b1, d, p);
    cyc(1'b0, 0, 1'b0);
  endtask

  task automatic code4(int a, int b, int c, int d);
    press(a, 1'b0); press(b, 1'b0); press(c, 1'b0); press(d, 1'b0);
  endtask

  task automatic edge_chk();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(string name, int max);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      edge_chk();
      if (state_o == 3'd0) done = 1'b1;
    end
    chk(name, int'(done), 1);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_locked"},   int'(locked),    1);
    chk({tag, "_unlocked"}, int'(unlocked),  0);
    chk({tag, "_error"},    int'(error),     0);
    chk({tag, "_lockout"},  int'(lockout_o), 0);
    chk({tag, "_state"},    int'(state_o),   0);
    chk({tag, "_idx"},      int'(digit_idx), 0);
    chk({tag, "_fail"},     int'(fail_cnt),  0);
  endtask

  typedef struct {
    bit en;
    int d;
    bit p;
    int st;
    int idx;
    int fail;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1, 1'b0, 1, 1, 0};
    tbl[1] = '{1'b0, 0, 1'b0, 1, 1, 0};
    tbl[2] = '{1'b1, 2, 1'b0, 1, 2, 0};
    tbl[3] = '{1'b0, 0, 1'b0, 1, 2, 0};
    tbl[4] = '{1'b1, 3, 1'b0, 1, 3, 0};
    tbl[5] = '{1'b0, 0, 1'b0, 1, 3, 0};
    tbl[6] = '{1'b1, 4, 1'b0, 2, 0, 0};
    tbl[7] = '{1'b0, 0, 1'b0, 3, 0, 0};
    tbl[8] = '{1'b0, 0, 1'b0, 3, 0, 0};

    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    #1 reset = 1'b0;
    chk_on = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].en, tbl[i].d, tbl[i].p);
      edge_chk();
      chk("tbl_state", int'(state_o),   tbl[i].st);
      chk("tbl_idx",   int'(digit_idx), tbl[i].idx);
      chk("tbl_fail",  int'(fail_cnt),  tbl[i].fail);
    end
    repeat (18) @(posedge clk);
    #2 chk("unlock_window_open", int'(unlocked), 1);
    edge_chk();
    chk("auto_relock", int'(locked), 1);

    // Wrong code: failure shows only after the fourth digit, error lasts EC cycles.
    press(1, 1'b0); press(2, 1'b0); press(9, 1'b0);
    chk("wrong_no_early_err", int'(error), 0);
    press(4, 1'b0);
    chk("wrong_check_state", int'(state_o), 2);
    edge_chk();
    chk("wrong_err", int'(error), 1);
    chk("wrong_fail", int'(fail_cnt), 1);
    repeat (4) @(posedge clk);
    #2 chk("wrong_err_held", int'(error), 1);
    edge_chk();
    chk("wrong_err_end", int'(error), 0);
    chk("wrong_relocked", int'(locked), 1);

    // Entry timeout keeps fail_cnt; a held enter counts once.
    press(1, 1'b0);
    repeat (6) @(posedge clk);
    #2 chk("tmo_still_entry", int'(state_o), 1);
    repeat (2) @(posedge clk);
    #2 chk("tmo_state", int'(state_o), 0);
    chk("tmo_idx", int'(digit_idx), 0);
    chk("tmo_fail", int'(fail_cnt), 1);
    cyc(1'b1, 1, 1'b0);
    repeat (5) @(posedge clk);
    #2 chk("hold_one_press", int'(digit_idx), 1);
    repeat (5) @(posedge clk);
    cyc(1'b0, 0, 1'b0);
    wait_idle("hold_idle", 20);

    // Lockout on the third consecutive failure; presses ignored while locked out.
    code4(9, 9, 9, 9);
    wait_idle("err2_idle", 20);
    code4(0, 0, 0, 0);
    edge_chk();
    chk("lockout_on", int'(lockout_o), 1);
    chk("lockout_fail", int'(fail_cnt), 3);
    press(1, 1'b0);
    chk("lockout_ignore_idx", int'(digit_idx), 0);
    chk("lockout_still", int'(lockout_o), 1);
    wait_idle("lockout_idle", 20);
    chk("lockout_fail_clr", int'(fail_cnt), 0);

    // Reprogram to 5678.
    code4(1, 2, 3, 4);
    edge_chk();
    chk("prog_unlock", int'(unlocked), 1);
    press(0, 1'b1);
    chk("prog_state", int'(state_o), 6);
    code4(5, 6, 7, 8);
    chk("prog_commit", int'(state_o), 0);
    code4(1, 2, 3, 4);
    edge_chk();
    chk("old_code_fails", int'(error), 1);
    wait_idle("old_code_idle", 20);
    code4(5, 6, 7, 8);
    edge_chk();
    chk("new_code_unlocks", int'(unlocked), 1);

    // Reset mid-PROGRAM and mid-ENTRY.
    press(0, 1'b1);
    press(1, 1'b0);
    chk("mid_prog_idx", int'(digit_idx), 1);
    reset = 1'b1;
    #1 chk_reset_outputs("rst_prog");
    @(negedge clk); #1 reset = 1'b0;
    press(1, 1'b0); press(2, 1'b0);
    reset = 1'b1;
    #1 chk_reset_outputs("rst_entry");
    @(negedge clk); #1 reset = 1'b0;
    code4(1, 2, 3, 4);
    edge_chk();
    chk("rst_restores_code", int'(unlocked), 1);
    press(0, 1'b0);
    chk("manual_relock", int'(locked), 1);

    // Random presses, mostly with the digit the model expects next.
    for (int n = 0; n < 500; n++) begin
      int k;
      int dsel;
      k = (m_st == 1) ? m_q.size() : 0;
      if (k > 3) k = 0;
      dsel = ($urandom_range(0, 9) < 8) ? m_code[k] : int'($urandom_range(0, 15));
      cyc(($urandom_range(0, 2) == 0), dsel, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
